act_seg_ctrl: RTL and testbench

Piecewise-linear activation controller for the NPU core. It holds a table of per-segment (a, b) coefficients and lower breakpoints, picks a segment for each incoming signed sample, and drives the single-cycle linear datapath (result = a·x + b, one register stage, no stall input). Results are buffered in an output FIFO under credit control, so downstream back-pressure never loses datapath output. It sits between the activation input stream and the post-activation writeback path.

---
 rtl/act_seg_if.sv | 36 +++
 rtl/act_seg_ctrl.sv | 117 +++++++++++
 tb/tb_act_seg_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/act_seg_if.sv
// act_seg_if: control, sample, datapath and result bus of the activation controller
interface act_seg_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COE_A_WIDTH = 8,
  parameter int COE_B_WIDTH = 16,
  parameter int SEG_AW      = 3,
  parameter int LEN_WIDTH   = 16
);
  logic                               i_cfg_we;
  logic [SEG_AW-1:0]                  i_cfg_addr;
  logic [COE_A_WIDTH+COE_B_WIDTH-1:0] i_cfg_coe;
  logic [DATA_WIDTH-1:0]              i_cfg_bp;
  logic                               i_start;
  logic [LEN_WIDTH-1:0]               i_len;
  logic                               o_busy;
  logic                               o_done;
  logic                               i_dat_vld;
  logic                               o_dat_rdy;
  logic [DATA_WIDTH-1:0]              i_dat;
  logic [COE_A_WIDTH+COE_B_WIDTH-1:0] o_lin_coe;
  logic [DATA_WIDTH-1:0]              o_lin_dat;
  logic [2*DATA_WIDTH-1:0]            i_lin_result;
  logic                               o_res_vld;
  logic                               i_res_rdy;
  logic [2*DATA_WIDTH-1:0]            o_res_dat;
  modport master (
    output i_cfg_we, i_cfg_addr, i_cfg_coe, i_cfg_bp, i_start, i_len,
    output i_dat_vld, i_dat, i_lin_result, i_res_rdy,
    input  o_busy, o_done, o_dat_rdy, o_lin_coe, o_lin_dat, o_res_vld, o_res_dat
  );
  modport slave (
    input  i_cfg_we, i_cfg_addr, i_cfg_coe, i_cfg_bp, i_start, i_len,
    input  i_dat_vld, i_dat, i_lin_result, i_res_rdy,
    output o_busy, o_done, o_dat_rdy, o_lin_coe, o_lin_dat, o_res_vld, o_res_dat
  );
endinterface

// File: rtl/act_seg_ctrl.sv
// act_seg_ctrl: piecewise-linear activation controller; selects a segment per sample,
// feeds the external a*x+b datapath and buffers its results in a credit-guarded FIFO.
module act_seg_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int COE_A_WIDTH = 8,
  parameter int COE_B_WIDTH = 16,
  parameter int SEG_AW      = 3,
  parameter int LEN_WIDTH   = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input logic      i_clk,
  input logic      i_rst_n,
  act_seg_if.slave bus
);
  localparam int SEG_NUM = 1 << SEG_AW;
  localparam int CW      = COE_A_WIDTH + COE_B_WIDTH;
  localparam int RW      = 2 * DATA_WIDTH;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int NW      = AW + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t                             state_q, state_d;
  logic [SEG_NUM-1:0][CW-1:0]         coe_q, coe_d;
  logic [SEG_NUM-1:0][DATA_WIDTH-1:0] bp_q, bp_d;
  logic [FIFO_DEPTH-1:0][RW-1:0]      mem_q, mem_d;
  logic [LEN_WIDTH-1:0]               rem_q, rem_d;
  logic [NW-1:0]                      cnt_q, cnt_d;
  logic [AW-1:0]                      wr_q, wr_d, rd_q, rd_d;
  logic                               v1_q, v1_d, v2_q, v2_d, done_q, done_d;
  logic [CW-1:0]                      lin_coe_q, lin_coe_d;
  logic [DATA_WIDTH-1:0]              lin_dat_q, lin_dat_d;
  logic [SEG_AW-1:0]                  seg;
  logic [NW:0]                        credit;
  logic                               rdy, acc, pop;
  // Highest segment whose breakpoint is not above the sample; ties favour the higher index.
  always_comb begin
    seg = '0;
    for (int k = 0; k < SEG_NUM; k++)
      if ($signed(bp_q[k]) <= $signed(bus.i_dat)) seg = SEG_AW'(k);
  end
  // Results already in flight (v1, v2) hold reserved FIFO slots.
  assign credit = {1'b0, cnt_q} + {{NW{1'b0}}, v1_q} + {{NW{1'b0}}, v2_q};
  assign rdy    = (state_q == RUN) && (credit < (NW+1)'(FIFO_DEPTH));
  assign acc    = bus.i_dat_vld && rdy;
  assign pop    = (cnt_q != '0) && bus.i_res_rdy;
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    v1_d      = acc;
    v2_d      = v1_q;
    lin_dat_d = acc ? bus.i_dat : lin_dat_q;
    lin_coe_d = acc ? coe_q[seg] : lin_coe_q;
    rem_d     = acc ? rem_q - LEN_WIDTH'(1) : rem_q;
    wr_d      = wr_q + AW'(v2_q);
    rd_d      = rd_q + AW'(pop);
    cnt_d     = cnt_q + NW'(v2_q) - NW'(pop);
    mem_d     = mem_q;
    coe_d     = coe_q;
    bp_d      = bp_q;
    if (v2_q) mem_d[wr_q] = bus.i_lin_result;
    if (state_q == IDLE && bus.i_cfg_we) begin
      coe_d[bus.i_cfg_addr] = bus.i_cfg_coe;
      bp_d[bus.i_cfg_addr]  = bus.i_cfg_bp;
    end
    case (state_q)
      IDLE: if (bus.i_start) begin
        if (bus.i_len != '0) begin
          state_d = RUN;
          rem_d   = bus.i_len;
        end else done_d = 1'b1;
      end
      RUN: if (acc && rem_q == LEN_WIDTH'(1)) state_d = DRAIN;
      // Leave on the edge that empties the pipe so o_done follows the last pop directly.
      DRAIN: if (!v1_q && cnt_d == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q   <= IDLE;
      coe_q     <= '0;
      bp_q      <= '0;
      mem_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      done_q    <= 1'b0;
      lin_coe_q <= '0;
      lin_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      coe_q     <= coe_d;
      bp_q      <= bp_d;
      mem_q     <= mem_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      done_q    <= done_d;
      lin_coe_q <= lin_coe_d;
      lin_dat_q <= lin_dat_d;
    end
  assign bus.o_busy    = state_q != IDLE;
  assign bus.o_done    = done_q;
  assign bus.o_dat_rdy = rdy;
  assign bus.o_lin_coe = lin_coe_q;
  assign bus.o_lin_dat = lin_dat_q;
  assign bus.o_res_vld = cnt_q != '0;
  assign bus.o_res_dat = mem_q[rd_q];
endmodule

// File: tb/tb_act_seg_ctrl.sv
// tb_act_seg_ctrl: directed bench for act_seg_ctrl with a one-stage a*x+b datapath model
module tb_act_seg_ctrl;
  logic i_clk = 1'b0;
  logic i_rst_n;
  always #5 i_clk = ~i_clk;
  act_seg_if bus ();
  act_seg_ctrl dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));
  logic signed [15:0] pa, px, pb, lin_res;
  assign pa = {{8{bus.o_lin_coe[23]}}, bus.o_lin_coe[23:16]};
  assign px = {{8{bus.o_lin_dat[7]}}, bus.o_lin_dat};
  assign pb = bus.o_lin_coe[15:0];
  always @(posedge i_clk) lin_res <= pa * px + pb;
  assign bus.i_lin_result = lin_res;
  int n_chk = 0, n_err = 0;
  int cyc = 0, n_acc, n_done, first_acc, first_vld, last_pop, done_cyc, rdy_drop, stab_err, cur_len;
  bit busy_seen, rdy_seen, abort, hold_v;
  logic [15:0] hold_d;
  logic signed [15:0] got_q[$];
  int smp[32];
  int m_a[8], m_b[8], m_bp[8];
  int t1x[5] = '{-100, -16, 3, 64, 127};
  int t1y[5] = '{0, -16, 11, 164, 227};
  always @(posedge i_clk) cyc <= cyc + 1;
  always @(negedge i_clk) begin
    if (bus.o_busy && n_acc < cur_len && !bus.o_dat_rdy) rdy_drop++;
    if (bus.i_dat_vld && bus.o_dat_rdy) begin
      if (first_acc < 0) first_acc = cyc;
      n_acc++;
    end
    if (bus.o_res_vld && first_vld < 0) first_vld = cyc;
    if (bus.o_res_vld && bus.i_res_rdy) begin
      got_q.push_back(bus.o_res_dat);
      last_pop = cyc;
    end
    if (bus.o_res_vld && !bus.i_res_rdy) begin
      if (hold_v && bus.o_res_dat !== hold_d) stab_err++;
      hold_v = 1'b1;
      hold_d = bus.o_res_dat;
    end else hold_v = 1'b0;
    if (bus.o_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (bus.o_busy) busy_seen = 1'b1;
    if (bus.o_dat_rdy) rdy_seen = 1'b1;
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int model(input int x);
    int k = 0;
    for (int i = 0; i < 8; i++) if (m_bp[i] <= x) k = i;
    return m_a[k] * x + m_b[k];
  endfunction
  task automatic clr();
    got_q.delete();
    n_acc = 0; n_done = 0; first_acc = -1; first_vld = -1; last_pop = -1; done_cyc = -1;
    rdy_drop = 0; stab_err = 0; cur_len = 0; busy_seen = 0; rdy_seen = 0; abort = 0;
  endtask
  task automatic cfg(input int addr, input int a, input int b, input int bp);
    bus.i_cfg_we = 1'b1; bus.i_cfg_addr = 3'(addr);
    bus.i_cfg_coe = {8'(a), 16'(b)}; bus.i_cfg_bp = 8'(bp);
    @(posedge i_clk); #1;
    bus.i_cfg_we = 1'b0;
  endtask
  task automatic program_std();
    int bpv[8] = '{-128, -16, 0, 64, 64, 64, 64, 64};
    int av[8]  = '{0, 1, 2, 1, 1, 1, 1, 1};
    int bv[8]  = '{0, 0, 5, 100, 100, 100, 100, 100};
    for (int i = 0; i < 8; i++) begin
      cfg(i, av[i], bv[i], bpv[i]);
      m_a[i] = av[i]; m_b[i] = bv[i]; m_bp[i] = bpv[i];
    end
  endtask
  task automatic start_job(input int len);
    bus.i_start = 1'b1; bus.i_len = 16'(len);
    @(posedge i_clk); #1;
    bus.i_start = 1'b0;
  endtask
  task automatic stream(input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      bus.i_dat = 8'(smp[i]); bus.i_dat_vld = 1'b1; ok = 1'b0;
      for (int w = 0; w < 200 && !ok && !abort; w++) begin
        @(negedge i_clk);
        ok = bus.o_dat_rdy;
      end
      if (abort) break;
      if (!ok) begin
        chk("accept_timeout", 0, 1);
        break;
      end
      @(posedge i_clk); #1;
    end
    bus.i_dat_vld = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    for (int w = 0; w < 400 && n_done == 0; w++) @(posedge i_clk);
    repeat (3) @(posedge i_clk);
    #1;
    chk({tag, "_done_once"}, n_done, 1);
    chk({tag, "_busy_low"}, 32'(bus.o_busy), 0);
  endtask
  task automatic cmp_model(input string tag, input int n);
    chk({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) chk({tag, "_res"}, got_q[i], model(smp[i]));
  endtask
  initial begin
    i_rst_n = 1'b0;
    bus.i_cfg_we = 0; bus.i_cfg_addr = 0; bus.i_cfg_coe = 0; bus.i_cfg_bp = 0;
    bus.i_start = 0; bus.i_len = 0; bus.i_dat_vld = 0; bus.i_dat = 0; bus.i_res_rdy = 1;
    clr();
    @(negedge i_clk);
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_done", 32'(bus.o_done), 0);
    chk("rst_rdy", 32'(bus.o_dat_rdy), 0);
    chk("rst_lin_coe", 32'(bus.o_lin_coe), 0);
    chk("rst_lin_dat", 32'(bus.o_lin_dat), 0);
    chk("rst_res_vld", 32'(bus.o_res_vld), 0);
    chk("rst_res_dat", 32'(bus.o_res_dat), 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    // segment selection and pass-through of datapath results
    program_std();
    clr();
    for (int i = 0; i < 5; i++) smp[i] = t1x[i];
    start_job(5);
    chk("t1_busy", 32'(bus.o_busy), 1);
    stream(5);
    wait_done("t1");
    chk("t1_count", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) chk("t1_res", got_q[i], t1y[i]);
    // sustained throughput and latency
    clr();
    for (int i = 0; i < 16; i++) smp[i] = i * 16 - 128;
    cur_len = 16;
    start_job(16);
    stream(16);
    wait_done("t2");
    chk("t2_rdy_drops", rdy_drop, 0);
    chk("t2_first_latency", first_vld - first_acc, 3);
    chk("t2_done_after_pop", done_cyc - last_pop, 1);
    cmp_model("t2", 16);
    // back-pressure: credit caps acceptance at FIFO depth
    clr();
    for (int i = 0; i < 10; i++) smp[i] = i * 25 - 125;
    bus.i_res_rdy = 1'b0;
    start_job(10);
    fork stream(10); join_none
    repeat (20) @(posedge i_clk);
    #1;
    chk("t3_accepted", n_acc, 4);
    chk("t3_rdy_low", 32'(bus.o_dat_rdy), 0);
    chk("t3_res_vld", 32'(bus.o_res_vld), 1);
    bus.i_res_rdy = 1'b1;
    wait_done("t3");
    chk("t3_stable", stab_err, 0);
    cmp_model("t3", 10);
    // cfg write and restart during RUN are ignored
    clr();
    for (int i = 0; i < 3; i++) smp[i] = 3;
    start_job(3);
    fork
      stream(3);
      begin
        bus.i_cfg_we = 1'b1; bus.i_cfg_addr = 3'd2; bus.i_cfg_coe = {8'sd5, 16'sd0}; bus.i_cfg_bp = 8'sd0;
        bus.i_start = 1'b1; bus.i_len = 16'd5;
        @(posedge i_clk); #1;
        bus.i_cfg_we = 1'b0; bus.i_start = 1'b0;
      end
    join
    wait_done("t4");
    chk("t4_count", got_q.size(), 3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) chk("t4_res", got_q[i], 11);
    clr();
    start_job(1);
    stream(1);
    wait_done("t4b");
    chk("t4b_count", got_q.size(), 1);
    if (got_q.size() > 0) chk("t4b_old_coe", got_q[0], 11);
    // zero-length job
    clr();
    start_job(0);
    repeat (5) @(posedge i_clk);
    #1;
    chk("t5_done", n_done, 1);
    chk("t5_busy_seen", 32'(busy_seen), 0);
    chk("t5_rdy_seen", 32'(rdy_seen), 0);
    // reset mid-job
    clr();
    for (int i = 0; i < 8; i++) smp[i] = i * 10;
    start_job(8);
    fork
      stream(8);
      begin
        for (int w = 0; w < 100 && n_acc < 3; w++) begin
          @(negedge i_clk); #1;
        end
        @(posedge i_clk); #2;
        abort = 1'b1;
        bus.i_dat_vld = 1'b0;
        i_rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(bus.o_busy), 0);
        chk("t6_rdy", 32'(bus.o_dat_rdy), 0);
        chk("t6_lin_coe", 32'(bus.o_lin_coe), 0);
        chk("t6_lin_dat", 32'(bus.o_lin_dat), 0);
        chk("t6_res_vld", 32'(bus.o_res_vld), 0);
        chk("t6_res_dat", 32'(bus.o_res_dat), 0);
        repeat (3) @(posedge i_clk);
        #1;
        chk("t6_accepted", n_acc, 3);
        chk("t6_no_done", n_done, 0);
        i_rst_n = 1'b1;
      end
    join
    clr();
    smp[0] = 5;
    start_job(1);
    stream(1);
    wait_done("t6a");
    chk("t6a_count", got_q.size(), 1);
    if (got_q.size() > 0) chk("t6a_table_cleared", got_q[0], 0);
    program_std();
    clr();
    smp[0] = 3; smp[1] = 64;
    start_job(2);
    stream(2);
    wait_done("t6b");
    chk("t6b_count", got_q.size(), 2);
    if (got_q.size() > 1) begin
      chk("t6b_res0", got_q[0], 11);
      chk("t6b_res1", got_q[1], 164);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
